// File: rtl/lsu_wb_pkg.sv
// Shared types and helpers for the LSU writeback arbiter.
// Holds the buffered completion entry, width constants and the RR helper.
package lsu_wb_pkg;

    localparam int PRF_AW = 6;
    localparam int DATA_W = 64;
    localparam int ROB_W  = 5;

    typedef struct packed {
        logic              prf_we;
        logic [PRF_AW-1:0] rd_addr;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob_index;
    } lsu_wb_entry_t;

    // Next round-robin start: one past the last source granted.
    function automatic int rr_next(input int last, input int n);
        return (last + 1) % n;
    endfunction

endpackage

// File: rtl/lsu_wb_src_buf.sv
// Per-source circular completion buffer: one push, one pop per cycle.
// Ports: clk/rstn, flush_i clears; push_i/entry_i, pop_i/head_o, empty_o, count_o.
module lsu_wb_src_buf
    import lsu_wb_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  lsu_wb_entry_t                entry_i,
    input  logic                         pop_i,
    output lsu_wb_entry_t                head_o,
    output logic                         empty_o,
    output logic [$clog2(BUF_DEPTH):0]   count_o
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(BUF_DEPTH);

    lsu_wb_entry_t mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];
    // Guards keep the buffer consistent even if the caller misbehaves.
    assign do_push = push_i & (count != CNT_MAX) & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry_i;
    end

endmodule

// File: rtl/lsu_prf_wb_arb.sv
// LSU writeback arbiter: buffers N completion sources, grants P ports round-robin.
// Ports: src_* inputs with src_rdy_o; prf_wb_* PRF write ports; lsq_wb_* completions.
module lsu_prf_wb_arb
    import lsu_wb_pkg::*;
#(
    parameter int SRC_COUNT          = 3,
    parameter int WB_PORT_COUNT      = 1,
    parameter int BUF_DEPTH          = 4,
    parameter int PHY_REG_ADDR_WIDTH = PRF_AW,
    parameter int XLEN               = DATA_W,
    parameter int ROB_INDEX_WIDTH    = ROB_W
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        flush_i,
    input  logic [SRC_COUNT-1:0]                        src_vld_i,
    input  logic [SRC_COUNT-1:0]                        src_prf_we_i,
    input  logic [SRC_COUNT*PHY_REG_ADDR_WIDTH-1:0]     src_rd_addr_i,
    input  logic [SRC_COUNT*XLEN-1:0]                   src_data_i,
    input  logic [SRC_COUNT*ROB_INDEX_WIDTH-1:0]        src_rob_index_i,
    output logic [SRC_COUNT-1:0]                        src_rdy_o,
    output logic [WB_PORT_COUNT-1:0]                    prf_wb_vld_o,
    output logic [WB_PORT_COUNT*PHY_REG_ADDR_WIDTH-1:0] prf_wb_rd_addr_o,
    output logic [WB_PORT_COUNT*XLEN-1:0]               prf_wb_data_o,
    output logic [WB_PORT_COUNT-1:0]                    lsq_wb_vld_o,
    output logic [WB_PORT_COUNT*ROB_INDEX_WIDTH-1:0]    lsq_wb_rob_index_o
);

    localparam int SW = $clog2(SRC_COUNT);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int AW = PHY_REG_ADDR_WIDTH;
    localparam int RW = ROB_INDEX_WIDTH;
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

    lsu_wb_entry_t            in_e  [SRC_COUNT];
    lsu_wb_entry_t            head  [SRC_COUNT];
    logic [CW-1:0]            cnt   [SRC_COUNT];
    logic [SRC_COUNT-1:0]     empty;
    logic [SRC_COUNT-1:0]     push;
    logic [SRC_COUNT-1:0]     pop;
    logic [SW-1:0]            rr_ptr;
    logic [2*SRC_COUNT-1:0]   ne_dbl;
    logic [SRC_COUNT-1:0]     ne_rot;
    logic                     sel_vld [WB_PORT_COUNT];
    int                       sel_src [WB_PORT_COUNT];
    int                       n_grant;
    int                       last_src;

    for (genvar g = 0; g < SRC_COUNT; g++) begin : g_src
        assign in_e[g].prf_we    = src_prf_we_i[g];
        assign in_e[g].rd_addr   = src_rd_addr_i[g*AW +: AW];
        assign in_e[g].data      = src_data_i[g*XLEN +: XLEN];
        assign in_e[g].rob_index = src_rob_index_i[g*RW +: RW];
        assign src_rdy_o[g]      = (cnt[g] != CNT_FULL) & ~flush_i;
        assign push[g]           = src_vld_i[g] & src_rdy_o[g];

        lsu_wb_src_buf #(
            .BUF_DEPTH (BUF_DEPTH)
        ) u_buf (
            .clk     (clk),
            .rstn    (rstn),
            .flush_i (flush_i),
            .push_i  (push[g]),
            .entry_i (in_e[g]),
            .pop_i   (pop[g]),
            .head_o  (head[g]),
            .empty_o (empty[g]),
            .count_o (cnt[g])
        );
    end

    // Rotate the non-empty mask so bit k is source (rr_ptr + k) mod N.
    assign ne_dbl = {~empty, ~empty} >> rr_ptr;
    assign ne_rot = ne_dbl[SRC_COUNT-1:0];

    always_comb begin
        n_grant  = 0;
        last_src = 0;
        for (int p = 0; p < WB_PORT_COUNT; p++) begin
            sel_vld[p] = 1'b0;
            sel_src[p] = 0;
        end
        if (!flush_i) begin
            for (int k = 0; k < SRC_COUNT; k++) begin
                if (ne_rot[k] && n_grant < WB_PORT_COUNT) begin
                    last_src = (int'(rr_ptr) + k) % SRC_COUNT;
                    for (int p = 0; p < WB_PORT_COUNT; p++) begin
                        if (p == n_grant) begin
                            sel_vld[p] = 1'b1;
                            sel_src[p] = last_src;
                        end
                    end
                    n_grant = n_grant + 1;
                end
            end
        end
    end

    always_comb begin
        pop                = '0;
        prf_wb_vld_o       = '0;
        prf_wb_rd_addr_o   = '0;
        prf_wb_data_o      = '0;
        lsq_wb_vld_o       = '0;
        lsq_wb_rob_index_o = '0;
        for (int p = 0; p < WB_PORT_COUNT; p++) begin
            for (int s = 0; s < SRC_COUNT; s++) begin
                if (sel_vld[p] && sel_src[p] == s) begin
                    pop[s]                         = 1'b1;
                    lsq_wb_vld_o[p]                = 1'b1;
                    lsq_wb_rob_index_o[p*RW +: RW] = head[s].rob_index;
                    prf_wb_vld_o[p]                = head[s].prf_we;
                    if (head[s].prf_we) begin
                        prf_wb_rd_addr_o[p*AW +: AW]   = head[s].rd_addr;
                        prf_wb_data_o[p*XLEN +: XLEN] = head[s].data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (flush_i) begin
            rr_ptr <= '0;
        end else if (n_grant != 0) begin
            rr_ptr <= SW'(rr_next(last_src, SRC_COUNT));
        end
    end

endmodule

// File: tb/tb_lsu_prf_wb_arb.sv
// Scoreboard bench for lsu_prf_wb_arb with a queue-based reference model.
// Driver pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_lsu_prf_wb_arb;

    localparam int N  = 3;
    localparam int P  = 1;
    localparam int D  = 4;
    localparam int AW = 6;
    localparam int XW = 64;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            flush_i;
    logic [N-1:0]    src_vld_i;
    logic [N-1:0]    src_prf_we_i;
    logic [N*AW-1:0] src_rd_addr_i;
    logic [N*XW-1:0] src_data_i;
    logic [N*RW-1:0] src_rob_index_i;
    logic [N-1:0]    src_rdy_o;
    logic [P-1:0]    prf_wb_vld_o;
    logic [P*AW-1:0] prf_wb_rd_addr_o;
    logic [P*XW-1:0] prf_wb_data_o;
    logic [P-1:0]    lsq_wb_vld_o;
    logic [P*RW-1:0] lsq_wb_rob_index_o;

    always #5 clk = ~clk;

    lsu_prf_wb_arb dut (
        .clk                (clk),
        .rstn               (rstn),
        .flush_i            (flush_i),
        .src_vld_i          (src_vld_i),
        .src_prf_we_i       (src_prf_we_i),
        .src_rd_addr_i      (src_rd_addr_i),
        .src_data_i         (src_data_i),
        .src_rob_index_i    (src_rob_index_i),
        .src_rdy_o          (src_rdy_o),
        .prf_wb_vld_o       (prf_wb_vld_o),
        .prf_wb_rd_addr_o   (prf_wb_rd_addr_o),
        .prf_wb_data_o      (prf_wb_data_o),
        .lsq_wb_vld_o       (lsq_wb_vld_o),
        .lsq_wb_rob_index_o (lsq_wb_rob_index_o)
    );

    typedef struct {
        bit          we;
        bit [AW-1:0] rd;
        bit [XW-1:0] data;
        bit [RW-1:0] rob;
    } ent_t;

    typedef struct {
        bit [N-1:0]  rdy;
        bit          pv;
        bit          lv;
        bit [AW-1:0] a;
        bit [XW-1:0] d;
        bit [RW-1:0] r;
    } exp_t;

    ent_t mq [N][$];
    ent_t pay [N];
    exp_t sb [$];
    exp_t mon_e;
    bit   acc [N];
    int   rr;
    int   errs = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL sb_underflow: got none expected 1 record");
            end else begin
                mon_e = sb.pop_front();
                chk("src_rdy", 64'(src_rdy_o), 64'(mon_e.rdy));
                chk("prf_vld", 64'(prf_wb_vld_o), 64'(mon_e.pv));
                chk("lsq_vld", 64'(lsq_wb_vld_o), 64'(mon_e.lv));
                chk("prf_addr", 64'(prf_wb_rd_addr_o), 64'(mon_e.a));
                chk("prf_data", prf_wb_data_o, mon_e.d);
                chk("lsq_rob", 64'(lsq_wb_rob_index_o), 64'(mon_e.r));
            end
        end
    end

    function automatic ent_t rnd_ent();
        ent_t e;
        e.we   = 1'($urandom_range(0, 1));
        e.rd   = AW'($urandom);
        e.data = {$urandom, $urandom};
        e.rob  = RW'($urandom);
        return e;
    endfunction

    // One cycle: drive inputs, record what the outputs must be, advance model.
    task automatic step(input bit [N-1:0] vld, input bit fl);
        exp_t e;
        int   gl;
        int   ng;
        int   s;
        @(posedge clk);
        #1;
        src_vld_i = vld;
        flush_i   = fl;
        for (int i = 0; i < N; i++) begin
            src_prf_we_i[i]             = pay[i].we;
            src_rd_addr_i[i*AW +: AW]   = pay[i].rd;
            src_data_i[i*XW +: XW]      = pay[i].data;
            src_rob_index_i[i*RW +: RW] = pay[i].rob;
        end
        e  = '{rdy: '0, pv: 0, lv: 0, a: '0, d: '0, r: '0};
        gl = -1;
        ng = 0;
        for (int i = 0; i < N; i++)
            e.rdy[i] = !fl && mq[i].size() < D;
        if (!fl) begin
            for (int k = 0; k < N; k++) begin
                s = (rr + k) % N;
                if (mq[s].size() > 0 && ng < P) begin
                    e.lv = 1'b1;
                    e.pv = mq[s][0].we;
                    e.r  = mq[s][0].rob;
                    if (mq[s][0].we) begin
                        e.a = mq[s][0].rd;
                        e.d = mq[s][0].data;
                    end
                    gl = s;
                    ng++;
                end
            end
        end
        sb.push_back(e);
        mon_en = 1'b1;
        if (fl) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                acc[i] = 1'b0;
            end
            rr = 0;
        end else begin
            for (int i = 0; i < N; i++)
                acc[i] = vld[i] && mq[i].size() < D;
            if (gl >= 0) begin
                void'(mq[gl].pop_front());
                rr = (gl + 1) % N;
            end
            for (int i = 0; i < N; i++)
                if (acc[i]) mq[i].push_back(pay[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_prf_vld"}, 64'(prf_wb_vld_o), 64'd0);
        chk({tag, "_lsq_vld"}, 64'(lsq_wb_vld_o), 64'd0);
        chk({tag, "_addr"}, 64'(prf_wb_rd_addr_o), 64'd0);
        chk({tag, "_data"}, prf_wb_data_o, 64'd0);
        chk({tag, "_rob"}, 64'(lsq_wb_rob_index_o), 64'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) mq[i].delete();
        rr = 0;
    endtask

    int seq [N];

    initial begin
        rstn = 1'b0;
        flush_i = 1'b0;
        src_vld_i = '0;
        src_prf_we_i = '0;
        src_rd_addr_i = '0;
        src_data_i = '0;
        src_rob_index_i = '0;
        for (int i = 0; i < N; i++) pay[i] = rnd_ent();
        clear_model();
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

        // idle after reset: ready all ones, nothing valid
        repeat (2) step('0, 0);

        // single completion from source 1
        pay[1] = '{we: 1'b1, rd: 6'd5, data: 64'hDEAD, rob: 5'd7};
        step(3'b010, 0);
        repeat (3) step('0, 0);

        // fairness: rob encodes source, so order errors show as rob errors
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                pay[i] = rnd_ent();
                pay[i].rob = RW'(i * 8 + c);
            end
            step(3'b111, 0);
        end
        repeat (16) step('0, 0);

        // backpressure: sources 0 and 2 stream, payload held until accepted
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            pay[i] = rnd_ent();
            pay[i].rob = RW'(i * 10);
        end
        for (int c = 0; c < 16; c++) begin
            step(3'b101, 0);
            for (int i = 0; i < N; i += 2) begin
                if (acc[i]) begin
                    seq[i]++;
                    pay[i] = rnd_ent();
                    pay[i].rob = RW'(i * 10 + seq[i]);
                end
            end
        end
        repeat (20) step('0, 0);

        // ROB-only completion
        pay[0] = '{we: 1'b0, rd: 6'd9, data: 64'h1234, rob: 5'd3};
        step(3'b001, 0);
        repeat (2) step('0, 0);

        // flush with entries in every buffer, then lowest source wins
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) pay[i] = rnd_ent();
            step(3'b111, 0);
        end
        step(3'b111, 1);
        step('0, 0);
        for (int i = 0; i < N; i++) pay[i] = rnd_ent();
        step(3'b110, 0);
        repeat (4) step('0, 0);

        // random traffic with occasional flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) pay[i] = rnd_ent();
            step(N'($urandom), ($urandom_range(0, 39) == 0));
        end

        // reset asserted mid-traffic
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) pay[i] = rnd_ent();
            step(3'b111, 0);
        end
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        src_vld_i = '0;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        chk("midrst_rdy", 64'(src_rdy_o), 64'h7);
        clear_model();
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) step('0, 0);
        for (int i = 0; i < N; i++) pay[i] = rnd_ent();
        step(3'b100, 0);
        repeat (3) step('0, 0);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
